z80_bus_arbiter: RTL and testbench



---
 rtl/z80_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares the Z80 external bus between the CPU and up to
// four DMA-style requesters through the nBUSRQ/nBUSACK handshake.
// Requesters are served round-robin. Each grant is followed by a minimum
// number of CPU-owned clocks before the next bus request.
//
// Optional feature: define Z80_ARB_TIMEOUT_EN to revoke grants held for
// MAX_HOLD clocks. A revoked requester stays masked until it drops req.
// Without the macro, a grant lasts until req drops and timeout is tied 0.

module z80_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MIN_GAP  = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            nBUSRQ,
  input  logic            nBUSACK,
  output logic            bus_owned,
  output logic            timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } state_t;

  state_t     state;
  logic [1:0] ptr;         // first requester to scan at the next arbitration
  logic [1:0] win;         // requester holding the current grant
  logic [1:0] pick_idx;
  logic       pick_found;
  logic [3:0] req4;        // req widened to the maximum requester count
  logic [3:0] elig4;
  logic [3:0] gap_cnt;
  logic       hold_done;

  assign req4 = 4'(req);

`ifdef Z80_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;
  logic [3:0]  mask4;      // requesters revoked by timeout, cleared when req drops

  assign elig4     = req4 & ~mask4;
  assign hold_done = (hold_cnt == 16'(MAX_HOLD - 1));
`else
  assign elig4     = req4;
  assign hold_done = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Round-robin pick: first eligible requester at or after ptr, wrapping at NREQ.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && elig4[2'((int'(ptr) + i) % NREQ)]) begin
        pick_found = 1'b1;
        pick_idx   = 2'((int'(ptr) + i) % NREQ);
      end
    end
  end

  // Bus ownership sequencer with registered grant, nBUSRQ and timeout outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      win       <= 2'd0;
      gap_cnt   <= 4'd0;
      gnt       <= '0;
      nBUSRQ    <= 1'b1;
      bus_owned <= 1'b0;
`ifdef Z80_ARB_TIMEOUT_EN
      hold_cnt  <= 16'd0;
      mask4     <= 4'd0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef Z80_ARB_TIMEOUT_EN
      // NOTE: non-blocking throughout; later assignments in this block override
      // these per-cycle defaults without creating ordering hazards.
      timeout <= 1'b0;
      mask4   <= mask4 & req4;
`endif
      case (state)
        ST_IDLE: begin
          if (|elig4) begin
            nBUSRQ <= 1'b0;
            state  <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (!nBUSACK) begin
            if (pick_found) begin
              for (int j = 0; j < NREQ; j++) begin
                gnt[j] <= (pick_idx == 2'(j));
              end
              bus_owned <= 1'b1;
              win       <= pick_idx;
              ptr       <= 2'((int'(pick_idx) + 1) % NREQ);
              state     <= ST_GRANT;
`ifdef Z80_ARB_TIMEOUT_EN
              hold_cnt  <= 16'd0;
`endif
            end else begin
              // Requests vanished before the CPU let go: hand the bus straight back.
              nBUSRQ <= 1'b1;
              state  <= ST_RELEASE;
            end
          end
        end

        ST_GRANT: begin
`ifdef Z80_ARB_TIMEOUT_EN
          hold_cnt <= hold_cnt + 16'd1;
`endif
          // A CPU that withdraws its ack (e.g. CPU reset) ends the grant too.
          if (!req4[win] || nBUSACK) begin
            gnt       <= '0;
            bus_owned <= 1'b0;
            nBUSRQ    <= 1'b1;
            state     <= ST_RELEASE;
          end else if (hold_done) begin
            gnt       <= '0;
            bus_owned <= 1'b0;
            nBUSRQ    <= 1'b1;
            state     <= ST_RELEASE;
`ifdef Z80_ARB_TIMEOUT_EN
            timeout    <= 1'b1;
            mask4[win] <= 1'b1;
`endif
          end
        end

        ST_RELEASE: begin
          if (nBUSACK) begin
            gap_cnt <= 4'd0;
            state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt == 4'(MIN_GAP - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter: directed and random stimulus for z80_bus_arbiter.
// A transaction-level reference model predicts every output change
// (cycle, gnt, nBUSRQ, timeout) into a queue; an independent monitor pops
// and compares whenever the DUT outputs change. A small CPU model answers
// nBUSRQ with nBUSACK after a programmable delay.

module tb_z80_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MIN_GAP  = 4;
  localparam int MAX_HOLD = 8;
`ifdef Z80_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] req     = 4'd0;
  logic       nbusack = 1'b1;
  logic [3:0] gnt;
  logic       nbusrq;
  logic       bus_owned;
  logic       timeout;

  always #5 clk = ~clk;

  z80_bus_arbiter #(
    .NREQ    (NREQ),
    .MIN_GAP (MIN_GAP),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .nBUSRQ   (nbusrq),
    .nBUSACK  (nbusack),
    .bus_owned(bus_owned),
    .timeout  (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       n;
    logic       t;
  } ev_t;

  ev_t        evq[$];
  int         cyc    = 0;
  logic [3:0] exp_g  = 4'd0;
  logic       exp_n  = 1'b1;
  logic       exp_t  = 1'b0;
  int         m_ptr  = 0;
  logic [3:0] m_mask = 4'd0;
  logic [3:0] s_req  = 4'd0;
  logic [3:0] elig   = 4'd0;
  logic       s_ack  = 1'b1;
  logic       s_rst  = 1'b1;
  bit         aborted;

  function automatic int pick(input logic [3:0] e, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (e[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Record an expected output change at the current cycle.
  task automatic emit(input logic [3:0] g, input logic n, input logic t);
    ev_t e;
    if (g == exp_g && n == exp_n && t == exp_t) return;
    exp_g = g; exp_n = n; exp_t = t;
    e.cyc = cyc; e.g = g; e.n = n; e.t = t;
    if (evq.size() > 0 && evq[evq.size()-1].cyc == cyc) evq[evq.size()-1] = e;
    else evq.push_back(e);
  endtask

  // Advance to just after the next edge and capture what that edge sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    s_req = req;
    s_ack = nbusack;
    s_rst = reset;
    if (s_rst) begin
      aborted = 1'b1;
      m_ptr   = 0;
      m_mask  = 4'd0;
      emit(4'd0, 1'b1, 1'b0);
    end else begin
      if (exp_t) emit(exp_g, exp_n, 1'b0);
      elig   = s_req & ~m_mask;
      m_mask = m_mask & s_req;
    end
  endtask

  initial begin : model
    int w;
    int hold;
    forever begin
      aborted = 1'b0;
      // CPU owns the bus: wait for an eligible request.
      do tick(); while (!aborted && elig == 4'd0);
      if (aborted) continue;
      emit(4'd0, 1'b0, 1'b0);
      // Wait for the CPU to release the bus.
      do tick(); while (!aborted && s_ack);
      if (aborted) continue;
      w = pick(elig, m_ptr);
      if (w >= 0) begin
        emit(4'b0001 << w, 1'b0, 1'b0);
        m_ptr = (w + 1) % NREQ;
        hold  = 0;
        do begin
          tick();
          hold++;
        end while (!aborted && s_req[w] && !s_ack && !(TO_EN && hold == MAX_HOLD));
        if (aborted) continue;
        if (!s_req[w] || s_ack) begin
          emit(4'd0, 1'b1, 1'b0);
        end else begin
          emit(4'd0, 1'b1, 1'b1);
          m_mask[w] = 1'b1;
        end
      end else begin
        emit(4'd0, 1'b1, 1'b0);
      end
      // Wait for the CPU to take the bus back, then the guaranteed CPU gap.
      do tick(); while (!aborted && !s_ack);
      if (aborted) continue;
      for (int i = 0; i < MIN_GAP && !aborted; i++) tick();
    end
  end

  // -------------------------------------------------------------- monitor
  logic [3:0] p_g = 4'd0;
  logic       p_n = 1'b1;
  logic       p_b = 1'b0;
  logic       p_t = 1'b0;
  logic [3:0] glog[$];
  int         to_cnt = 0;

  initial begin : monitor
    ev_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (s_rst) check("reset_state", {gnt, nbusrq, bus_owned, timeout}, {4'd0, 1'b1, 1'b0, 1'b0});
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        check("missed_event_cycle", cyc, e.cyc);
      end
      if ({gnt, nbusrq, bus_owned, timeout} !== {p_g, p_n, p_b, p_t}) begin
        if (gnt != 4'd0 && gnt != p_g) glog.push_back(gnt);
        if (timeout && !p_t) to_cnt++;
        if (evq.size() == 0) begin
          check("unexpected_change", {gnt, nbusrq, bus_owned, timeout}, {p_g, p_n, p_b, p_t});
        end else begin
          e = evq.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("gnt", gnt, e.g);
          check("nbusrq", nbusrq, e.n);
          check("bus_owned", bus_owned, |e.g);
          check("timeout", timeout, e.t);
        end
        p_g = gnt; p_n = nbusrq; p_b = bus_owned; p_t = timeout;
      end
    end
  end

  // ------------------------------------------------------------ CPU model
  int ack_dly   = 3;
  int rel_dly   = 1;
  bit cpu_drop  = 1'b0;

  initial begin : cpu
    int dn = 0;
    int up = 0;
    bit dropped = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_drop) begin
        nbusack  = 1'b1;
        dropped  = 1'b1;
        cpu_drop = 1'b0;
        dn       = 0;
      end else if (nbusrq === 1'b0) begin
        up = 0;
        if (!dropped) begin
          dn++;
          if (dn >= ack_dly) nbusack = 1'b0;
        end
      end else begin
        dn      = 0;
        dropped = 1'b0;
        up++;
        if (up >= rel_dly) nbusack = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    glog.delete();
    to_cnt = 0;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    int n = 0;
    while (gnt == 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_gnt_in_time", 32'(n < 200), 32'd1);
    g = gnt;
  endtask

  initial begin : main
    logic [3:0] g;
    int rr_exp[5] = '{1, 2, 4, 8, 1};
    int rem[4];
    bit got[4];

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single requester, grant, release, and immediate re-request.
    do_reset();
    ack_dly = 3; rel_dly = 1;
    req = 4'b0001;
    wait_gnt(g);
    repeat (3) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(g);
    repeat (2) @(negedge clk);
    req = 4'b0000;
    repeat (12) @(negedge clk);
    check("single_grants", glog.size(), 2);
    check("single_first", glog[0], 4'b0001);

    // Round-robin with all four requesting, five-clock grants.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      repeat (4) @(negedge clk);
      req = req & ~g;
      @(negedge clk);
      req = req | g;
    end
    req = 4'b0000;
    repeat (15) @(negedge clk);
    check("rr_grants", glog.size(), 5);
    for (int k = 0; k < 5; k++) check("rr_order", glog[k], rr_exp[k]);

    // Request withdrawn before the CPU acknowledges.
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    repeat (20) @(negedge clk);
    check("withdraw_no_grant", glog.size(), 0);

    // Reset during a grant; pointer must restart at requester 0.
    do_reset();
    req = 4'b0100;
    wait_gnt(g);
    check("rst_first_gnt", g, 4'b0100);
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b1001;
    @(negedge clk);
    reset = 1'b0;
    check("rst_outputs", {gnt, nbusrq, bus_owned}, {4'd0, 1'b1, 1'b0});
    wait_gnt(g);
    check("rst_next_gnt", g, 4'b0001);
    req = 4'b0000;
    repeat (15) @(negedge clk);

    // Long hold: revoked after MAX_HOLD with the timeout feature, else kept.
    do_reset();
    req = 4'b0001;
    wait_gnt(g);
    repeat (25) @(negedge clk);
    check("hold_gnt_after_25", gnt, TO_EN ? 4'b0000 : 4'b0001);
    check("timeout_pulses", to_cnt, TO_EN ? 1 : 0);
    check("no_regrant_while_held", glog.size(), 1);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    wait_gnt(g);
    check("regrant_after_rerequest", g, 4'b0001);
    req = 4'b0000;
    repeat (15) @(negedge clk);

    // CPU drops nBUSACK in the middle of a grant.
    do_reset();
    req = 4'b0010;
    wait_gnt(g);
    @(negedge clk);
    cpu_drop = 1'b1;
    repeat (3) @(negedge clk);
    check("cpu_drop_gnt", gnt, 4'b0000);
    req = 4'b0000;
    repeat (15) @(negedge clk);

    // Random traffic with varying CPU latency, CPU drops and resets.
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      got[i] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 97 == 0) begin
        ack_dly = int'($urandom_range(4, 1));
        rel_dly = int'($urandom_range(3, 1));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(7) == 0) begin
            req[i] = 1'b1;
            rem[i] = int'($urandom_range(12, 1));
            got[i] = 1'b0;
          end
        end else begin
          if (gnt[i]) got[i] = 1'b1;
          if (got[i]) begin
            rem[i]--;
            if (rem[i] <= 0) req[i] = 1'b0;
          end else if ($urandom_range(63) == 0) begin
            req[i] = 1'b0;
          end
        end
      end
      if (gnt != 4'd0 && $urandom_range(299) == 0) cpu_drop = 1'b1;
      reset = ($urandom_range(999) == 0);
    end
    reset = 1'b0;
    req   = 4'd0;
    repeat (40) @(negedge clk);
    check("scoreboard_drained", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
